// File: rtl/avg_tree_pipe_pkg.sv
// Shared constants and helpers for the pipelined averaging adder tree.
// LOG and SUMW describe the default 8 x 16-bit configuration.
package avg_tree_pipe_pkg;

  function automatic int avg_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int avg_sumw(input int dw, input int n);
    return dw + avg_log2(n);
  endfunction

  localparam int DATAWIDTH_DEF = 16;
  localparam int NUM_IN_DEF    = 8;
  localparam int LOG           = avg_log2(NUM_IN_DEF);
  localparam int SUMW          = DATAWIDTH_DEF + LOG;

endpackage

// File: rtl/avg_tree_pipe_if.sv
// Sample/result bus of avg_tree_pipe.
// Handshake: valid-only, no ready; a sample is taken on every edge with
// in_valid=1, and out_valid pulses for exactly one cycle per result.
interface avg_tree_pipe_if #(
  parameter int DATAWIDTH = 16,
  parameter int NUM_IN    = 8,
  parameter int SAWIDTH   = 8
);
  logic                        in_valid;
  logic [NUM_IN*DATAWIDTH-1:0] in_data;
  logic [SAWIDTH-1:0]          sa;
  logic                        rnd;
  logic                        out_valid;
  logic [DATAWIDTH-1:0]        avg;
  logic                        ovf;

  modport master (
    output in_valid, in_data, sa, rnd,
    input  out_valid, avg, ovf
  );

  modport slave (
    input  in_valid, in_data, sa, rnd,
    output out_valid, avg, ovf
  );
endinterface

// File: rtl/avg_add_stage.sv
// One adder-tree level: PAIRS registered pairwise sums of IN_W-bit operands,
// widened by one bit, with valid/sa/rnd carried alongside.
module avg_add_stage #(
  parameter int IN_W    = 16,
  parameter int PAIRS   = 4,
  parameter int SAWIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  input  logic [2*PAIRS*IN_W-1:0]    data_i,
  input  logic [SAWIDTH-1:0]         sa_i,
  input  logic                       rnd_i,
  output logic                       valid_o,
  output logic [PAIRS*(IN_W+1)-1:0]  data_o,
  output logic [SAWIDTH-1:0]         sa_o,
  output logic                       rnd_o
);

  localparam int OUT_W = IN_W + 1;

  logic                      valid_q;
  logic [PAIRS*OUT_W-1:0]    sum_q, sum_d;
  logic [SAWIDTH-1:0]        sa_q;
  logic                      rnd_q;

  always_comb begin
    sum_d = '0;
    for (int p = 0; p < PAIRS; p++) begin
      sum_d[p*OUT_W +: OUT_W] = {1'b0, data_i[(2*p)*IN_W +: IN_W]}
                              + {1'b0, data_i[(2*p+1)*IN_W +: IN_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      sa_q    <= '0;
      rnd_q   <= 1'b0;
    end else begin
      valid_q <= valid_i;
      sum_q   <= sum_d;
      sa_q    <= sa_i;
      rnd_q   <= rnd_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = sum_q;
  assign sa_o    = sa_q;
  assign rnd_o   = rnd_q;

endmodule

// File: rtl/avg_tree_pipe.sv
// Pipelined average: LOG adder-tree stages followed by a registered
// round / shift / saturate stage. Latency LOG+1, one sample per cycle.
module avg_tree_pipe
  import avg_tree_pipe_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int NUM_IN    = 8,
  parameter int SAWIDTH   = 8
) (
  input logic            clk,
  input logic            rst,
  avg_tree_pipe_if.slave bus
);

  localparam int STAGES = avg_log2(NUM_IN);
  localparam int SUM_W  = avg_sumw(DATAWIDTH, NUM_IN);
  localparam logic [SAWIDTH:0] SA_LIM = (SAWIDTH+1)'(SUM_W + 1);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW    = DATAWIDTH + k;
    localparam int PAIRS = NUM_IN >> (k + 1);

    logic                      v_in, r_in, v_out, r_out;
    logic [2*PAIRS*IW-1:0]     d_in;
    logic [PAIRS*(IW+1)-1:0]   d_out;
    logic [SAWIDTH-1:0]        s_in, s_out;

    if (k == 0) begin : g_first
      assign v_in = bus.in_valid;
      assign d_in = bus.in_data;
      assign s_in = bus.sa;
      assign r_in = bus.rnd;
    end else begin : g_next
      assign v_in = g_stage[k-1].v_out;
      assign d_in = g_stage[k-1].d_out;
      assign s_in = g_stage[k-1].s_out;
      assign r_in = g_stage[k-1].r_out;
    end

    avg_add_stage #(
      .IN_W    (IW),
      .PAIRS   (PAIRS),
      .SAWIDTH (SAWIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .valid_i (v_in),
      .data_i  (d_in),
      .sa_i    (s_in),
      .rnd_i   (r_in),
      .valid_o (v_out),
      .data_o  (d_out),
      .sa_o    (s_out),
      .rnd_o   (r_out)
    );
  end

  logic                 valid_s, rnd_s;
  logic [SUM_W-1:0]     sum_s;
  logic [SAWIDTH-1:0]   sa_s;

  assign valid_s = g_stage[STAGES-1].v_out;
  assign sum_s   = g_stage[STAGES-1].d_out;
  assign sa_s    = g_stage[STAGES-1].s_out;
  assign rnd_s   = g_stage[STAGES-1].r_out;

  logic [SUM_W:0]       half_d, t_d, r_d;
  logic [DATAWIDTH-1:0] avg_d;
  logic                 ovf_d;

  // t is one bit wider than the sum so the rounding increment cannot wrap.
  always_comb begin
    half_d = '0;
    if (rnd_s && (sa_s != '0)) half_d = {{SUM_W{1'b0}}, 1'b1} << (sa_s - 1'b1);
    t_d = {1'b0, sum_s} + half_d;
    r_d = t_d >> sa_s;
    if ({1'b0, sa_s} >= SA_LIM) begin
      avg_d = '0;
      ovf_d = 1'b0;
    end else if (r_d[SUM_W:DATAWIDTH] != '0) begin
      avg_d = '1;
      ovf_d = 1'b1;
    end else begin
      avg_d = r_d[DATAWIDTH-1:0];
      ovf_d = 1'b0;
    end
  end

  logic                 out_valid_q;
  logic [DATAWIDTH-1:0] avg_q;
  logic                 ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      avg_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= valid_s;
      if (valid_s) begin
        avg_q <= avg_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.avg       = avg_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_avg_tree_pipe.sv
// Randomized self-checking bench for avg_tree_pipe (8 x 16-bit channels)
// against a plain-arithmetic reference model and a timed expected queue.
module tb_avg_tree_pipe;
  import avg_tree_pipe_pkg::*;

  localparam int DW  = 16;
  localparam int N   = 8;
  localparam int SAW = 8;
  localparam int EXP_W = 32 + 1 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  logic rst_seen = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  avg_tree_pipe_if #(.DATAWIDTH(DW), .NUM_IN(N), .SAWIDTH(SAW)) bus_if ();

  avg_tree_pipe #(.DATAWIDTH(DW), .NUM_IN(N), .SAWIDTH(SAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [EXP_W-1:0] exp_q[$];   // {due cycle, ovf, avg}
  logic [DW-1:0] last_avg = '0;
  logic          last_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Average of the channel sum, rounded/shifted/saturated from first principles.
  function automatic logic [DW:0] model(input logic [N*DW-1:0] d, input int s, input logic r);
    longint sum, t, res;
    sum = 0;
    for (int i = 0; i < N; i++) sum += longint'(d[i*DW +: DW]);
    if (s >= SUMW + 1) begin
      res = 0;
    end else begin
      t = sum;
      if (r && s != 0) t += longint'(1) << (s - 1);
      res = t >> s;
    end
    if (res > longint'((1 << DW) - 1)) return {1'b1, {DW{1'b1}}};
    return {1'b0, DW'(res)};
  endfunction

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    int due;
    if (cyc > 0) begin
      if (exp_q.size() > 0) begin
        e   = exp_q[0];
        due = int'(e[EXP_W-1 -: 32]);
        if (due < cyc) begin
          chk("lost_result_due", cyc, due);
          void'(exp_q.pop_front());
        end
      end
      if (rst_seen) begin
        chk("rst_out_valid", {31'b0, bus_if.out_valid}, 32'd0);
        chk("rst_avg", {16'b0, bus_if.avg}, 32'd0);
        chk("rst_ovf", {31'b0, bus_if.ovf}, 32'd0);
        last_avg = '0;
        last_ovf = 1'b0;
      end else if (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) == cyc) begin
        e = exp_q.pop_front();
        chk("out_valid_hi", {31'b0, bus_if.out_valid}, 32'd1);
        chk("avg", {16'b0, bus_if.avg}, {16'b0, e[DW-1:0]});
        chk("ovf", {31'b0, bus_if.ovf}, {31'b0, e[DW]});
        last_avg = e[DW-1:0];
        last_ovf = e[DW];
      end else begin
        chk("out_valid_lo", {31'b0, bus_if.out_valid}, 32'd0);
        chk("avg_hold", {16'b0, bus_if.avg}, {16'b0, last_avg});
        chk("ovf_hold", {31'b0, bus_if.ovf}, {31'b0, last_ovf});
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] v);
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = v;
    return d;
  endfunction

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    int mode;
    mode = $urandom_range(0, 3);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       d[i*DW +: DW] = DW'($urandom_range(16'hF000, 16'hFFFF));
        1:       d[i*DW +: DW] = DW'($urandom_range(0, 64));
        default: d[i*DW +: DW] = DW'($urandom);
      endcase
    end
    return d;
  endfunction

  function automatic logic [SAW-1:0] rand_sa();
    case ($urandom_range(0, 15))
      0:       return 8'd255;
      1:       return SAW'(SUMW);
      2:       return SAW'(SUMW + 1);
      default: return SAW'($urandom_range(0, 22));
    endcase
  endfunction

  task automatic drive(input logic v, input logic [N*DW-1:0] d, input logic [SAW-1:0] s,
                       input logic r);
    logic [DW:0]  res;
    logic [31:0]  due;
    @(posedge clk); #1;
    rst              = 1'b0;
    bus_if.in_valid  = v;
    bus_if.in_data   = d;
    bus_if.sa        = s;
    bus_if.rnd       = r;
    if (v) begin
      res = model(d, int'(s), r);
      due = 32'(cyc + 1 + LOG);
      exp_q.push_back({due, res});
    end
  endtask

  task automatic idle();
    drive(1'b0, rand_data(), rand_sa(), 1'($urandom_range(0, 1)));
  endtask

  // Results not yet visible before the reset edge are discarded.
  task automatic do_reset(input int n);
    logic [EXP_W-1:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst             = 1'b1;
      bus_if.in_valid = 1'($urandom_range(0, 1));
      bus_if.in_data  = rand_data();
      bus_if.sa       = rand_sa();
      bus_if.rnd      = 1'($urandom_range(0, 1));
      while (exp_q.size() > 0) begin
        e = exp_q[exp_q.size()-1];
        if (int'(e[EXP_W-1 -: 32]) > cyc) void'(exp_q.pop_back());
        else break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N*DW-1:0] ramp;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    bus_if.sa       = '0;
    bus_if.rnd      = 1'b0;
    for (int i = 0; i < N; i++) ramp[i*DW +: DW] = DW'(i + 1);

    do_reset(2);
    idle();

    drive(1'b1, ramp, 8'd3, 1'b0);              // 36>>3 = 4
    for (int i = 0; i < 5; i++) idle();
    drive(1'b1, ramp, 8'd3, 1'b1);              // (36+4)>>3 = 5
    drive(1'b1, fill(16'hFFFF), 8'd3, 1'b0);    // 0xFFFF, no ovf
    drive(1'b1, fill(16'hFFFF), 8'd0, 1'b0);    // saturates
    drive(1'b1, fill(16'hFFFF), 8'd20, 1'b1);   // shifted out entirely
    for (int i = 0; i < 5; i++) idle();

    drive(1'b1, fill(16'd1), 8'd3, 1'b0);
    drive(1'b1, fill(16'd2), 8'd3, 1'b0);
    drive(1'b1, fill(16'd3), 8'd3, 1'b0);
    idle();
    drive(1'b1, fill(16'd4), 8'd3, 1'b0);
    for (int i = 0; i < 5; i++) idle();

    drive(1'b1, fill(16'hFFFF), 8'd0, 1'b0);
    idle();
    do_reset(1);
    drive(1'b1, ramp, 8'd3, 1'b1);
    for (int i = 0; i < 6; i++) idle();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 2));
      else if ($urandom_range(0, 3) == 0) idle();
      else drive(1'b1, rand_data(), rand_sa(), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < LOG + 4; i++) idle();
    chk("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/avg_tree_pipe.md
AVG_TREE_PIPE -- requirements
Module: avg_tree_pipe

Interface
REQ-001 Parameter DATAWIDTH, default 16: width of each input channel and of avg.
REQ-002 Parameter NUM_IN, default 8: channel count; power of two, 2..16.
REQ-003 Parameter SAWIDTH, default 8: width of sa.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  in_data/sa/rnd sampled this cycle.
REQ-007 in_data  input  NUM_IN*DATAWIDTH  unsigned channels; channel i at bits [i*DATAWIDTH +: DATAWIDTH].
REQ-008 sa  input  SAWIDTH  unsigned right-shift amount applied to the sum.
REQ-009 rnd  input  1  1 = round-half-up, 0 = truncate.
REQ-010 out_valid  output  1  one-cycle pulse per accepted sample.
REQ-011 avg  output  DATAWIDTH  shifted, saturated sum.
REQ-012 ovf  output  1  saturation occurred for this result; valid with out_valid.

Function
REQ-013 LOG = log2(NUM_IN) and SUMW = DATAWIDTH+LOG SHALL be derived constants.
REQ-014 Sample SHALL be accepted on every cycle with in_valid=1; no backpressure, no stall.
REQ-015 Adder tree SHALL have LOG registered stages; stage k holds NUM_IN/2^k partial sums of width DATAWIDTH+k; no truncation.
REQ-016 sa, rnd and a valid bit SHALL travel with each sample through every stage.
REQ-017 Final registered stage SHALL compute t = sum + (rnd && sa!=0 ? 2^(sa-1) : 0) in SUMW+1 bits, then r = t >> sa.
REQ-018 sa >= SUMW+1 SHALL give r = 0, ovf = 0.
REQ-019 r > 2^DATAWIDTH-1 SHALL give avg = all ones, ovf = 1; otherwise avg = r[DATAWIDTH-1:0], ovf = 0.
REQ-020 Latency SHALL be LOG+1 cycles: in_valid at edge n -> out_valid at edge n+LOG+1.
REQ-021 Back-to-back samples SHALL produce back-to-back results, in order, with no bubbles and no loss.
REQ-022 Samples with in_valid=0 SHALL leave no result; pipeline bubbles pass through as bubbles.
REQ-023 avg and ovf SHALL hold their last values while out_valid=0.

Reset
REQ-024 With rst=1 at an edge: all valid bits, avg and ovf SHALL be 0 after that edge.
REQ-025 Samples in flight when rst asserts SHALL be discarded; they never produce out_valid.
REQ-026 in_valid with rst=1 in the same cycle SHALL be ignored.
REQ-027 The first sample accepted after rst deasserts SHALL follow REQ-020.

Structure
REQ-028 A shared package SHALL hold the log2 function and the derived constants LOG and SUMW.
REQ-029 One sub-module avg_add_stage SHALL be used: parameters IN_W and PAIRS; registered pairwise add with valid/sa/rnd pass-through and synchronous reset.
REQ-030 The top SHALL instantiate LOG avg_add_stage instances plus the shift/round/saturate register.

Verification (NUM_IN=8, DATAWIDTH=16)
REQ-031 Channels 1..8, sa=3, rnd=0 -> avg=4 (36>>3), ovf=0, exactly 4 cycles after input.
REQ-032 Same input, rnd=1 -> avg=5 ((36+4)>>3); channels all 0xFFFF, sa=3 -> avg=0xFFFF, ovf=0.
REQ-033 Channels all 0xFFFF, sa=0 -> sum 0x7FFF8 saturates -> avg=0xFFFF, ovf=1; sa=20 -> avg=0, ovf=0.
REQ-034 Three consecutive valid samples, sums 8/16/24, sa=3 -> out_valid high 3 consecutive cycles, avg 1,2,3 in order; then one bubble, one sample -> matching bubble in out_valid.
REQ-035 rst asserted 2 cycles after a valid sample -> no out_valid for it; outputs 0; next sample after release is correct at latency 4.
